// File: rtl/kernel_cc_sched_pkg.sv
// Shared types and the round-robin pick rule for the kernel_cc start-token scheduler.
package kernel_cc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    // Returns {found, index}: first set bit of req at or above ptr, wrapping at num_req-1.
    // Works on a 16-wide vector so any requester count up to 16 shares one definition.
    function automatic logic [4:0] rr_pick(input logic [3:0]  ptr,
                                           input logic [15:0] req,
                                           input logic [4:0]  num_req);
        logic [4:0] idx;
        rr_pick = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i < int'(num_req)) begin
                idx = {1'b0, ptr} + 5'(i);
                if (idx >= num_req)
                    idx = idx - num_req;
                if (req[idx[3:0]])
                    rr_pick = {1'b1, idx[3:0]};
            end
        end
    endfunction

endpackage

// File: rtl/kernel_cc_start_rr_pick.sv
// Combinational round-robin priority picker over the start FIFOs' empty_n flags.
module kernel_cc_start_rr_pick
    import kernel_cc_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic [NUM_REQ-1:0]  req,
    output logic                found,
    output logic [ID_WIDTH-1:0] grant
);

    logic [4:0] pick;

    assign pick  = rr_pick(4'(ptr), 16'(req), 5'(NUM_REQ));
    assign found = pick[4];
    assign grant = ID_WIDTH'(pick[3:0]);

endmodule

// File: rtl/kernel_cc_start_sched.sv
// Shares one ap_start/ap_ready/ap_done task among NUM_REQ dataflow producers,
// popping start tokens round-robin and returning a done token to the owner.
module kernel_cc_start_sched
    import kernel_cc_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_empty_n,
    output logic [NUM_REQ-1:0]   req_read,
    output logic                 ap_start,
    input  logic                 ap_ready,
    input  logic                 ap_done,
    output logic [ID_WIDTH-1:0]  task_id,
    input  logic [NUM_REQ-1:0]   done_full_n,
    output logic [NUM_REQ-1:0]   done_write,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_count
);

    state_t              state, state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] grant;
    logic                found;
    logic                pop, push;
    logic                task_full_n;

    kernel_cc_start_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .ptr   (rr_ptr),
        .req   (req_empty_n),
        .found (found),
        .grant (grant)
    );

    always_comb begin
        task_full_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (task_id == ID_WIDTH'(i))
                task_full_n = done_full_n[i];
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: if (found) begin
                state_nxt = START;
                pop       = 1'b1;
            end
            START: if (ap_ready)
                state_nxt = ap_done ? RESP : WAIT_DONE;
            WAIT_DONE: if (ap_done)
                state_nxt = RESP;
            RESP: if (task_full_n) begin
                state_nxt = IDLE;
                push      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by reset so FIFOs see no pop/push while reset is held.
    always_comb begin
        req_read   = '0;
        done_write = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_read[i]   = pop  && !reset && (grant   == ID_WIDTH'(i));
            done_write[i] = push && !reset && (task_id == ID_WIDTH'(i));
        end
    end

    assign ap_start = (state == START);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            task_id    <= '0;
            rr_ptr     <= '0;
            done_count <= '0;
        end else begin
            state <= state_nxt;
            if (pop)
                task_id <= grant;
            if (push) begin
                done_count <= done_count + CNT_WIDTH'(1);
                rr_ptr     <= (task_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : task_id + ID_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_kernel_cc_start_sched.sv
// Scoreboard bench for kernel_cc_start_sched: FIFO/task responders, round-robin reference model.
module tb_kernel_cc_start_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_empty_n, req_read, done_full_n, done_write;
    logic           ap_start, ap_ready, ap_done, busy;
    logic [IDW-1:0] task_id;
    logic [CW-1:0]  done_count;

    kernel_cc_start_sched #(.NUM_REQ(N), .ID_WIDTH(IDW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_empty_n (req_empty_n),
        .req_read    (req_read),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .task_id     (task_id),
        .done_full_n (done_full_n),
        .done_write  (done_write),
        .busy        (busy),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int tok [N];
    logic [N-1:0] rd_snap = '0;
    bit   rand_mode = 0, arrive = 0;
    int   rdy_dly = 0, dn_dly = 0, st_cnt = 0, dn_cnt = 0;

    // reference model state and logs
    bit m_busy = 0, dc_pending = 0;
    int m_ptr = 0, m_cnt = 0, n_rd = 0, n_wr = 0, start_cycles = 0;
    int exp_q[$], grant_log[$], rd_cyc_log[$], wr_cyc_log[$], st_log[$], dc_log[$];

    always_comb
        for (int i = 0; i < N; i++) req_empty_n[i] = (tok[i] > 0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Spec rule: first requester with a token, scanning upward from ptr with wrap.
    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Monitor: samples at negedge, compares against the model, pops expected done tokens.
    initial begin : monitor
        int  g, id;
        bit  was_busy;
        forever begin
            @(negedge clk);
            rd_snap = req_read;
            if (reset) begin
                m_busy = 0; m_ptr = 0; m_cnt = 0; dc_pending = 0;
                exp_q.delete();
                continue;
            end
            if (dc_pending) begin
                dc_log.push_back(int'(done_count));
                dc_pending = 0;
            end
            chk("done_count", done_count, m_cnt % (1 << CW));
            was_busy = m_busy;
            if (was_busy) begin
                chk("req_read_while_busy", req_read, 0);
                chk("busy_high", busy, 1);
                chk("task_id_stable", task_id, exp_q[0]);
                if (ap_start) start_cycles++;
            end else begin
                g = pick(m_ptr, req_empty_n);
                chk("busy_low", busy, 0);
                chk("ap_start_idle", ap_start, 0);
                chk("req_read", req_read, (g < 0) ? 0 : (1 << g));
                if (req_read != 0 && g >= 0) begin
                    m_busy = 1; exp_q.push_back(g); grant_log.push_back(g);
                    rd_cyc_log.push_back(cyc); start_cycles = 0; n_rd++;
                end
            end
            if (done_write != 0) begin
                if (!was_busy) chk("unexpected_done_write", done_write, 0);
                else begin
                    id = exp_q.pop_front();
                    chk("done_write", done_write, 1 << id);
                    chk("done_full_n_at_write", done_full_n[id], 1);
                    m_busy = 0; m_ptr = (id + 1) % N; m_cnt++; n_wr++;
                    wr_cyc_log.push_back(cyc); st_log.push_back(start_cycles);
                    dc_pending = 1;
                end
            end
        end
    end

    // Driver: FIFO token accounting and shared-task responder, updated just after each posedge.
    initial begin : driver
        ap_ready = 0; ap_done = 0; done_full_n = '1;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (rd_snap[i]) tok[i]--;
            ap_ready = 0; ap_done = 0;
            if (ap_start && !reset) begin
                if (st_cnt == 0 && rand_mode) begin
                    rdy_dly = $urandom_range(0, 3);
                    dn_dly  = $urandom_range(0, 3);
                end
                if (st_cnt == rdy_dly) begin
                    ap_ready = 1;
                    if (dn_dly == 0) ap_done = 1; else dn_cnt = dn_dly;
                end else if (rand_mode && $urandom_range(0, 3) == 0)
                    ap_done = 1;   // early done before ready must be ignored
                st_cnt++;
            end else begin
                st_cnt = 0;
                if (dn_cnt > 0) begin
                    dn_cnt--;
                    if (dn_cnt == 0) ap_done = 1;
                end
            end
            if (rand_mode) begin
                for (int i = 0; i < N; i++) done_full_n[i] = ($urandom_range(0, 3) != 0);
                if (arrive)
                    for (int i = 0; i < N; i++)
                        if ($urandom_range(0, 7) == 0 && tok[i] < 3) tok[i]++;
            end
        end
    end

    task automatic clear_logs();
        grant_log.delete(); rd_cyc_log.delete(); wr_cyc_log.delete();
        st_log.delete(); dc_log.delete(); n_rd = 0; n_wr = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
        clear_logs();
    endtask

    task automatic wait_cnt(input bit wr, input int n, input int bound, input string name);
        int k = 0;
        while (((wr ? n_wr : n_rd) < n) && k < bound) begin
            @(posedge clk); #2; k++;
        end
        chk(name, (wr ? n_wr : n_rd) >= n, 1);
    endtask

    initial begin : main
        int wr_before;
        for (int i = 0; i < N; i++) tok[i] = 0;
        reset = 1;
        repeat (3) @(posedge clk); #2;
        tok[1] = 1;
        #1;
        chk("rst_ap_start", ap_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_task_id", task_id, 0);
        chk("rst_done_count", done_count, 0);
        chk("rst_req_read", req_read, 0);
        chk("rst_done_write", done_write, 0);
        tok[1] = 0;
        reset = 0;
        clear_logs();

        // minimum latency, two back-to-back tokens on requester 2
        @(posedge clk); #2;
        tok[2] = 2;
        wait_cnt(1, 2, 30, "lat_timeout");
        chk("lat_grant0", qat(grant_log, 0), 2);
        chk("lat_grant1", qat(grant_log, 1), 2);
        chk("lat_rd_to_wr", qat(wr_cyc_log, 0) - qat(rd_cyc_log, 0), 2);
        chk("lat_start_cycles", qat(st_log, 0), 1);
        chk("lat_done_count", qat(dc_log, 0), 1);
        chk("lat_next_pop", qat(rd_cyc_log, 1) - qat(rd_cyc_log, 0), 3);

        // all requesters busy: fair rotation and done_count wrap
        do_reset();
        for (int i = 0; i < N; i++) tok[i] = 2;
        wait_cnt(1, 8, 80, "rr_timeout");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_grant%0d", i), qat(grant_log, i), i % N);
            chk($sformatf("rr_count%0d", i), qat(dc_log, i), (i + 1) % (1 << CW));
        end

        // ap_ready delayed 5 cycles
        do_reset();
        rdy_dly = 5;
        tok[3] = 1;
        wait_cnt(1, 1, 40, "dly_timeout");
        chk("dly_start_cycles", qat(st_log, 0), 6);
        chk("dly_grant", qat(grant_log, 0), 3);
        rdy_dly = 0;

        // done FIFO 1 full for 4 RESP cycles
        do_reset();
        done_full_n = 4'b1101;
        tok[1] = 1; tok[3] = 1;
        wait_cnt(0, 1, 20, "stall_rd_timeout");
        repeat (5) @(posedge clk); #2;
        done_full_n = '1;
        wait_cnt(1, 2, 30, "stall_timeout");
        chk("stall_rd_to_wr", qat(wr_cyc_log, 0) - qat(rd_cyc_log, 0), 6);
        chk("stall_grant0", qat(grant_log, 0), 1);
        chk("stall_grant1", qat(grant_log, 1), 3);

        // async reset in WAIT_DONE; the late ap_done must not write
        dn_dly = 10;
        tok[2] = 1;
        wait_cnt(0, 3, 20, "rst_rd_timeout");
        repeat (3) @(posedge clk); #2;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_task_id", task_id, 2);
        chk("pre_rst_ap_start", ap_start, 0);
        wr_before = n_wr;
        reset = 1;
        #1;
        chk("mid_rst_ap_start", ap_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_task_id", task_id, 0);
        chk("mid_rst_done_count", done_count, 0);
        @(posedge clk); #2;
        reset = 0;
        repeat (20) @(posedge clk); #2;
        chk("rst_no_write", n_wr, wr_before);
        dn_dly = 0;

        // randomized traffic, then drain
        clear_logs();
        rand_mode = 1; arrive = 1;
        repeat (3000) @(posedge clk);
        arrive = 0;
        begin
            int k = 0;
            while ((m_busy || tok[0] + tok[1] + tok[2] + tok[3] > 0) && k < 600) begin
                @(posedge clk); #2; k++;
            end
            chk("drain_timeout", k < 600, 1);
        end
        rand_mode = 0;
        done_full_n = '1;
        repeat (3) @(posedge clk);
        chk("rand_pops_eq_writes", n_rd, n_wr);
        chk("rand_activity", n_wr > 50, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
